// File: rtl/rcpu_loader.sv
// Boot-time program loader: assembles UART bytes into 16-bit words, writes program memory,
// then releases the RCPU. Optional trailing XOR checksum via RCPU_LOADER_CHECKSUM_EN.
module rcpu_loader #(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        start,
  output logic        cpu_resetq,
  input  logic [15:0] cpu_mem_write_address,
  input  logic        cpu_mem_write_enable,
  input  logic [15:0] cpu_mem_write_data,
  output logic [15:0] mem_write_address,
  output logic        mem_write_enable,
  output logic [15:0] mem_write_data,
  output logic        busy,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLenHi  = 3'd1,
    StLenLo  = 3'd2,
    StDataHi = 3'd3,
    StDataLo = 3'd4,
`ifdef RCPU_LOADER_CHECKSUM_EN
    StCheck  = 3'd5,
`endif
    StRun    = 3'd6,
    StError  = 3'd7
  } state_e;

  localparam logic [7:0]  SyncByte = 8'hA5;
  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);
`ifdef RCPU_LOADER_CHECKSUM_EN
  localparam state_e StDone = StCheck;
`else
  localparam state_e StDone = StRun;
`endif

  state_e      state_q, state_d;
  logic [15:0] words_q, words_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  hi_q, hi_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        cpu_resetq_q, cpu_resetq_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
`ifdef RCPU_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      words_q      <= '0;
      len_q        <= '0;
      hi_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_resetq_q <= 1'b0;
      busy_q       <= 1'b1;
      error_q      <= 1'b0;
`ifdef RCPU_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      words_q      <= words_d;
      len_q        <= len_d;
      hi_q         <= hi_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_resetq_q <= cpu_resetq_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
`ifdef RCPU_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Next-state
  always_comb begin
    state_d      = state_q;
    words_d      = words_q;
    len_d        = len_q;
    hi_d         = hi_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    // Status flags trail the state by one cycle, except start drops them at once.
    cpu_resetq_d = (state_q == StRun);
    busy_d       = !((state_q == StRun) || (state_q == StError));
    error_d      = (state_q == StError);
`ifdef RCPU_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    if (start) begin
      state_d      = StIdle;
      words_d      = '0;
      cpu_resetq_d = 1'b0;
      busy_d       = 1'b1;
      error_d      = 1'b0;
    end else if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (rx_data == SyncByte) begin
            state_d = StLenHi;
            words_d = '0;
`ifdef RCPU_LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
          end
        end
        StLenHi: begin
          hi_d    = rx_data;
          state_d = StLenLo;
`ifdef RCPU_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
        end
        StLenLo: begin
          len_d = {hi_q, rx_data};
`ifdef RCPU_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if ({1'b0, hi_q, rx_data} > MaxWords) begin
            state_d = StError;
          end else if ({hi_q, rx_data} == 16'd0) begin
            state_d = StDone;
          end else begin
            state_d = StDataHi;
          end
        end
        StDataHi: begin
          hi_d    = rx_data;
          state_d = StDataLo;
`ifdef RCPU_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
        end
        StDataLo: begin
          wr_en_d   = 1'b1;
          wr_addr_d = words_q;
          wr_data_d = {hi_q, rx_data};
          words_d   = words_q + 16'd1;
`ifdef RCPU_LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ rx_data;
`endif
          state_d   = ((words_q + 16'd1) == len_q) ? StDone : StDataHi;
        end
`ifdef RCPU_LOADER_CHECKSUM_EN
        StCheck: begin
          state_d = (rx_data == csum_q) ? StRun : StError;
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs: the port is handed to the CPU only once it is released, so the final
  // loader write (issued while the state is already RUN) still reaches memory.
  always_comb begin
    cpu_resetq   = cpu_resetq_q;
    busy         = busy_q;
    error        = error_q;
    words_loaded = words_q;
    if (cpu_resetq_q) begin
      mem_write_address = cpu_mem_write_address;
      mem_write_enable  = cpu_mem_write_enable;
      mem_write_data    = cpu_mem_write_data;
    end else begin
      mem_write_address = wr_addr_q;
      mem_write_enable  = wr_en_q;
      mem_write_data    = wr_data_q;
    end
  end

endmodule
